ddr_port_arbiter: RTL and testbench

Shares one DDR memory-controller command port between two requesters: the display line fetcher (read) and the fractal compute engine's pixel writer (write). It sits between both requesters and the MCB port command interface. It holds off all traffic until memory calibration completes, then grants one requester at a time and issues exactly one command per grant. Reads have priority, with an optional starvation guard for writes.

---
 rtl/ddr_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one MCB command port between a read requester
// (display line fetcher) and a write requester (pixel writer).
// One command per grant; reads have priority. Defining ARB_WR_FAIRNESS_EN
// adds a streak counter that forces a pending write in after MAX_RD_STREAK
// consecutive read grants.
module ddr_port_arbiter #(
  parameter int MAX_RD_STREAK = 4,
  parameter int DONE_TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_calib_done,
  input  logic        cmd_full,
  input  logic        rd_req,
  input  logic [5:0]  rd_bl,
  input  logic [29:0] rd_addr,
  input  logic        rd_done,
  output logic        rd_grant,
  input  logic        wr_req,
  input  logic [5:0]  wr_bl,
  input  logic [29:0] wr_addr,
  input  logic        wr_done,
  output logic        wr_grant,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        cmd_en,
  output logic        calib_ok,
  output logic        timeout_err
);

  typedef enum logic [1:0] {CALIB, IDLE, ISSUE, WAIT_DONE} state_t;

  // Parameter range guards, evaluated at elaboration.
  if (MAX_RD_STREAK < 1 || MAX_RD_STREAK > 15) begin : g_bad_streak
    $error("MAX_RD_STREAK out of range 1..15");
  end
  if (DONE_TIMEOUT < 1 || DONE_TIMEOUT > 65535) begin : g_bad_timeout
    $error("DONE_TIMEOUT out of range 1..65535");
  end

  localparam logic [15:0] TMO_LAST = 16'(DONE_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        calib_meta;
  logic [15:0] tcnt_q;
  logic        gnt_rd, gnt_wr, fire, fin, tmo, fair;

`ifdef ARB_WR_FAIRNESS_EN
  logic [3:0] streak_q;
  assign fair = (streak_q == 4'(MAX_RD_STREAK)) && wr_req;

  // Streak of read grants made while a write was waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        streak_q <= '0;
    else if (gnt_wr)                     streak_q <= '0;
    else if (state_q == IDLE && !wr_req) streak_q <= '0;
    else if (gnt_rd && wr_req)           streak_q <= streak_q + 4'd1;
  end
`else
  assign fair = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous calibration flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      calib_meta <= 1'b0;
      calib_ok   <= 1'b0;
    end else begin
      calib_meta <= mem_calib_done;
      calib_ok   <= calib_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CALIB;
    else          state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    gnt_rd  = 1'b0;
    gnt_wr  = 1'b0;
    fire    = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      CALIB:     if (calib_ok) state_d = IDLE;
      IDLE: begin
        if (fair)        gnt_wr = 1'b1;
        else if (rd_req) gnt_rd = 1'b1;
        else if (wr_req) gnt_wr = 1'b1;
        if (gnt_rd || gnt_wr) state_d = ISSUE;
      end
      ISSUE: if (!cmd_full) begin
        fire    = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Done from the requester that does not own the port is ignored.
        if ((rd_grant && rd_done) || (wr_grant && wr_done)) fin = 1'b1;
        else if (tcnt_q == TMO_LAST) begin
          tmo = 1'b1;
          fin = 1'b1;
        end
        if (fin) state_d = IDLE;
      end
      default: state_d = CALIB;
    endcase
  end

  // Grant, command fields, strobe, timeout counter and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_grant      <= 1'b0;
      wr_grant      <= 1'b0;
      cmd_instr     <= 3'b000;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
      cmd_en        <= 1'b0;
      tcnt_q        <= '0;
      timeout_err   <= 1'b0;
    end else begin
      cmd_en <= fire;
      if (gnt_rd || gnt_wr) begin
        rd_grant      <= gnt_rd;
        wr_grant      <= gnt_wr;
        cmd_instr     <= gnt_rd ? 3'b001 : 3'b000;
        cmd_bl        <= gnt_rd ? rd_bl : wr_bl;
        cmd_byte_addr <= (gnt_rd ? rd_addr : wr_addr) & ~30'h3;
      end
      if (fin) begin
        rd_grant <= 1'b0;
        wr_grant <= 1'b0;
      end
      if (fire)                        tcnt_q <= '0;
      else if (state_q == WAIT_DONE)   tcnt_q <= tcnt_q + 16'd1;
      if (tmo) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboarded bench for ddr_port_arbiter: directed scenarios followed by
// randomized request traffic checked against a transaction-level model.
module tb_ddr_port_arbiter;
  localparam int MAX_STREAK = 4;
  localparam int TMO        = 16;
`ifdef ARB_WR_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0, reset_n = 1'b0, mem_calib_done = 1'b0, cmd_full = 1'b0;
  logic        rd_req = 1'b0, rd_done = 1'b0, wr_req = 1'b0, wr_done = 1'b0;
  logic [5:0]  rd_bl = '0, wr_bl = '0;
  logic [29:0] rd_addr = '0, wr_addr = '0;
  logic        rd_grant, wr_grant, cmd_en, calib_ok, timeout_err;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;

  ddr_port_arbiter #(.MAX_RD_STREAK(MAX_STREAK), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .mem_calib_done(mem_calib_done), .cmd_full(cmd_full),
    .rd_req(rd_req), .rd_bl(rd_bl), .rd_addr(rd_addr), .rd_done(rd_done), .rd_grant(rd_grant),
    .wr_req(wr_req), .wr_bl(wr_bl), .wr_addr(wr_addr), .wr_done(wr_done), .wr_grant(wr_grant),
    .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr), .cmd_en(cmd_en),
    .calib_ok(calib_ok), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  typedef struct { logic [2:0] instr; logic [5:0] bl; logic [29:0] addr; } cmd_t;
  cmd_t exp_q[$];
  cmd_t exp_last;
  int checks = 0, errors = 0;

  // model state for random traffic
  bit rd_p, wr_p;
  int m_streak;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [46:0] outs();
    return {rd_grant, wr_grant, cmd_instr, cmd_bl, cmd_byte_addr, cmd_en, calib_ok, timeout_err};
  endfunction

  task automatic push_exp(input bit is_rd, input logic [5:0] bl, input logic [29:0] addr);
    cmd_t c;
    c.instr = is_rd ? 3'b001 : 3'b000;
    c.bl    = bl;
    c.addr  = {addr[29:2], 2'b00};
    exp_q.push_back(c);
    exp_last = c;
  endtask

  // Monitor: every command strobe must match the oldest expected command.
  initial begin
    bit prev = 1'b0;
    cmd_t c;
    forever begin
      @(negedge clk);
      if (reset_n && cmd_en) begin
        chk("cmd_en_pulse", 64'(prev), 64'd0);
        if (exp_q.size() == 0) chk("cmd_expected", 64'(exp_q.size()), 64'd1);
        else begin
          c = exp_q.pop_front();
          chk("cmd_instr", 64'(cmd_instr), 64'(c.instr));
          chk("cmd_bl", 64'(cmd_bl), 64'(c.bl));
          chk("cmd_addr", 64'(cmd_byte_addr), 64'(c.addr));
          chk("grant_vs_instr", 64'({rd_grant, wr_grant}), c.instr[0] ? 64'd2 : 64'd1);
        end
      end
      prev = reset_n && cmd_en;
    end
  end

  task automatic wait_grant();
    int n = 0;
    @(negedge clk);
    while (!(rd_grant || wr_grant) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("grant_wait_bound", 64'(n), 64'd0);
  endtask

  task automatic wait_en();
    int n = 0;
    @(negedge clk);
    while (!cmd_en && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("cmd_en_wait_bound", 64'(n), 64'd0);
  endtask

  // Pick next request set after a grant; the loser keeps waiting.
  task automatic next_reqs(input bit won_rd);
    if (won_rd) rd_p = ($urandom_range(0, 9) < 7);
    else        wr_p = ($urandom_range(0, 9) < 7);
    if (!rd_p && !wr_p) begin
      if ($urandom_range(0, 1) == 1) rd_p = 1'b1; else wr_p = 1'b1;
    end
    if (rd_p && !rd_req) begin rd_bl = 6'($urandom); rd_addr = 30'($urandom); end
    if (wr_p && !wr_req) begin wr_bl = 6'($urandom); wr_addr = 30'($urandom); end
    rd_req = rd_p;
    wr_req = wr_p;
  endtask

  // Reference arbitration: reads first, unless a write has waited through
  // MAX_STREAK read grants (fairness builds only).
  task automatic model_arb(output bit win_rd);
    bit force_wr = FAIR && wr_p && (m_streak == MAX_STREAK);
    win_rd = !force_wr && rd_p;
    if (win_rd) m_streak = wr_p ? m_streak + 1 : 0;
    else        m_streak = 0;
    push_exp(win_rd, win_rd ? rd_bl : wr_bl, win_rd ? rd_addr : wr_addr);
  endtask

  // Follow one grant from arbitration to done.
  task automatic run_grant(input bit exp_rd, input int stall, input int dly,
                           input bit pulse_other, input bit rnd_next);
    wait_grant();
    chk("grant_owner", 64'({rd_grant, wr_grant}), exp_rd ? 64'd2 : 64'd1);
    if (exp_rd) rd_req = 1'b0; else wr_req = 1'b0;
    if (stall > 0) begin
      cmd_full = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_no_en", 64'(cmd_en), 64'd0);
        chk("stall_fields", 64'({cmd_instr, cmd_bl, cmd_byte_addr}),
            64'({exp_last.instr, exp_last.bl, exp_last.addr}));
      end
      @(posedge clk); #1 cmd_full = 1'b0;
      @(negedge clk); chk("en_not_early", 64'(cmd_en), 64'd0);
      @(negedge clk); chk("en_after_full", 64'(cmd_en), 64'd1);
    end else wait_en();
    if (dly > 0) begin
      if (pulse_other && dly >= 2) begin
        @(posedge clk); #1;
        if (exp_rd) wr_done = 1'b1; else rd_done = 1'b1;
        @(posedge clk); #1 wr_done = 1'b0; rd_done = 1'b0;
        repeat (dly - 2) @(posedge clk);
        #1;
      end else begin
        repeat (dly) @(posedge clk);
        #1;
      end
    end
    chk("grant_held", 64'({rd_grant, wr_grant}), exp_rd ? 64'd2 : 64'd1);
    if (rnd_next) next_reqs(exp_rd);
    if (exp_rd) rd_done = 1'b1; else wr_done = 1'b1;
    @(posedge clk); #1 rd_done = 1'b0; wr_done = 1'b0;
    @(negedge clk);
    chk("grant_drop", 64'({rd_grant, wr_grant}), 64'd0);
  endtask

  initial begin
    bit pre_bad;
    bit win;
    int n;
    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(outs()), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // no traffic before calibration
    rd_req = 1'b1; rd_bl = 6'd5; rd_addr = 30'h1234567;
    pre_bad = 1'b0;
    repeat (50) begin @(negedge clk); pre_bad |= rd_grant | wr_grant | cmd_en | calib_ok; end
    chk("no_grant_precalib", 64'(pre_bad), 64'd0);
    push_exp(1'b1, 6'd5, 30'h1234567);
    @(posedge clk); #1 mem_calib_done = 1'b1;
    @(negedge clk); chk("calib_ok_c0", 64'(calib_ok), 64'd0);
    @(negedge clk); chk("calib_ok_c1", 64'(calib_ok), 64'd0);
    @(negedge clk); chk("calib_ok_c2", 64'(calib_ok), 64'd1);
    run_grant(1'b1, 0, 2, 1'b0, 1'b0);

    // write with unaligned address, done after 5 cycles
    wr_req = 1'b1; wr_bl = 6'd63; wr_addr = 30'h103;
    push_exp(1'b0, 6'd63, 30'h103);
    run_grant(1'b0, 0, 5, 1'b1, 1'b0);

    // 20-cycle command FIFO stall, done in the strobe cycle
    rd_req = 1'b1; rd_bl = 6'd17; rd_addr = 30'h2ABCDEF;
    push_exp(1'b1, 6'd17, 30'h2ABCDEF);
    run_grant(1'b1, 20, 0, 1'b0, 1'b0);

    // done never arrives: grant revoked after TMO wait cycles
    rd_req = 1'b1; rd_bl = 6'd1; rd_addr = 30'h40;
    push_exp(1'b1, 6'd1, 30'h40);
    wait_grant();
    rd_req = 1'b0;
    wait_en();
    n = 0;
    while (rd_grant && n < 100) begin n++; @(negedge clk); end
    chk("timeout_cycles", 64'(n), 64'(TMO));
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    wr_req = 1'b1; wr_bl = 6'd2; wr_addr = 30'h88;
    push_exp(1'b0, 6'd2, 30'h88);
    run_grant(1'b0, 0, 1, 1'b0, 1'b0);
    chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // reset in the middle of a grant
    rd_req = 1'b1; rd_bl = 6'd9; rd_addr = 30'h777;
    push_exp(1'b1, 6'd9, 30'h777);
    wait_grant();
    wait_en();
    @(posedge clk); #1 reset_n = 1'b0;
    #1 chk("reset_abort", 64'(outs()), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    pre_bad = 1'b0;
    repeat (3) begin @(negedge clk); pre_bad |= rd_grant | wr_grant | cmd_en; end
    chk("no_grant_during_resync", 64'(pre_bad), 64'd0);
    chk("calib_resync", 64'(calib_ok), 64'd1);
    push_exp(1'b1, 6'd9, 30'h777);
    run_grant(1'b1, 0, 3, 1'b0, 1'b0);
    chk("timeout_err_cleared", 64'(timeout_err), 64'd0);

    // randomized traffic against the reference model
    m_streak = 0;
    rd_p = 1'b1; wr_p = 1'b1;
    rd_bl = 6'($urandom); rd_addr = 30'($urandom);
    wr_bl = 6'($urandom); wr_addr = 30'($urandom);
    for (int r = 0; r < 80; r++) begin
      model_arb(win);
      rd_req = rd_p; wr_req = wr_p;
      run_grant(win, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                int'($urandom_range(0, 8)), $urandom_range(0, 1) == 1, 1'b1);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("no_timeout_random", 64'(timeout_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
